// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save-to-binary resolver: state encoding,
// chunk-count helper and default sizing.
package csa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } csa_state_e;

  localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
  localparam logic [1:0] ST_RUN  = 2'(S_RUN);
  localparam logic [1:0] ST_DONE = 2'(S_DONE);

  // Number of CHUNK-bit slices covering one (NN+1)-bit redundant word.
  function automatic int unsigned nchunk(input int unsigned nn, input int unsigned chunk);
    return (nn + chunk) / chunk;
  endfunction

  // Counter width; a single-slice resolver still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NN_DEF     = 16;
  localparam int unsigned CHUNK_DEF  = 4;
  localparam int unsigned NCHUNK_DEF = nchunk(NN_DEF, CHUNK_DEF);
  localparam int unsigned CNT_W_DEF  = cnt_width(NCHUNK_DEF);

endpackage

// File: rtl/csa_resolver_if.sv
// Valid/ready bundle between the compressor tree, the resolver and its consumer.
interface csa_resolver_if #(
  parameter int unsigned NN = csa_pkg::NN_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [NN:0]   in_sum;
  logic [NN:0]   in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [NN+1:0] out_result;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/csa_chunk_add.sv
// Combinational W-bit slice adder with carry in/out.
module csa_chunk_add #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);
  assign {cout_c, sum_c} = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
endmodule

// File: rtl/csa_resolver.sv
// Multi-cycle resolver: adds a latched (sum, carry) pair CHUNK bits per cycle
// and presents the exact NN+2-bit binary result behind a valid/ready handshake.
module csa_resolver
  import csa_pkg::*;
#(
  parameter int unsigned NN    = NN_DEF,
  parameter int unsigned CHUNK = CHUNK_DEF
) (
  input  logic           clk,
  input  logic           rst,
  csa_resolver_if.slave  bus
);
  localparam int unsigned RW  = NN + 2;
  localparam int unsigned NCH = nchunk(NN, CHUNK);
  localparam int unsigned PW  = NCH * CHUNK;
  localparam int unsigned CW  = cnt_width(NCH);

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    car_q, car_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    res_q, res_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_c, b_c, s_c;
  logic             co_c;
  logic             last_c;

  // Operands are zero-padded to whole slices, so the narrow top slice needs no special case.
  assign a_c    = CHUNK'(sum_q >> (32'(cnt_q) * CHUNK));
  assign b_c    = CHUNK'(car_q >> (32'(cnt_q) * CHUNK));
  assign last_c = (cnt_q == CW'(NCH - 1));

  csa_chunk_add #(.W(CHUNK)) u_add (
    .a      (a_c),
    .b      (b_c),
    .cin    (cy_q),
    .sum_c  (s_c),
    .cout_c (co_c)
  );

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    car_d       = car_q;
    cy_d        = cy_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sum_d      = PW'(bus.in_sum);
          car_d      = PW'(bus.in_carry);
          cy_d       = 1'b0;
          cnt_d      = '0;
          res_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        // Slices land in disjoint, pre-cleared bit ranges; the final carry only on the last slice.
        res_d = res_q | RW'(((PW+1)'({last_c & co_c, s_c})) << (32'(cnt_q) * CHUNK));
        cy_d  = co_c;
        cnt_d = cnt_q + CW'(1);
        if (last_c) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      car_q       <= '0;
      cy_q        <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      car_q       <= car_d;
      cy_q        <= cy_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = res_q;

endmodule
